// File: rtl/fetch_pkg.sv
// Shared fetch-pipeline definitions: sequencer state encoding, reset PC default
// and the word-alignment helper used for branch targets.
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } seq_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_front_seq_npc_mux.sv
// Next-PC priority select: taken branch, then held pending target, then the
// sequential PC back value. Redirect targets are forced to word alignment.
module npc_mux
  import fetch_pkg::*;
(
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        pend_valid,
  input  logic [31:0] pend_target,
  input  logic [31:0] pc_back_in,
  output logic [31:0] npc,
  output logic        redirect
);

  always_comb begin
    npc      = pc_back_in;
    redirect = 1'b0;
    if (branch_taken) begin
      npc      = word_align(branch_target);
      redirect = 1'b1;
    end else if (pend_valid) begin
      npc      = word_align(pend_target);
      redirect = 1'b1;
    end
  end

endmodule

// File: rtl/pc_front_seq.sv
// PC-front register and redirect sequencer. Branches seen during a stall are
// held in PEND and applied when LE returns; each applied redirect flushes.
module pc_front_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LE,
  input  logic [31:0]      pc_back_in,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      npc_out,
  output logic [31:0]      pc_front_out,
  output logic             redirect_pending,
  output logic             flush_out,
  output logic             align_fault,
  output logic [CNT_W-1:0] redirect_count
);

  seq_state_e       state_q, state_d;
  logic [31:0]      pend_target_q, pend_target_d;
  logic [31:0]      pc_front_q, pc_front_d;
  logic             flush_q, flush_d;
  logic             align_fault_q, align_fault_d;
  logic [CNT_W-1:0] redirect_count_q, redirect_count_d;

  logic [31:0] npc;
  logic        redirect;

  npc_mux u_npc_mux (
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pend_valid    (state_q == PEND),
    .pend_target   (pend_target_q),
    .pc_back_in    (pc_back_in),
    .npc           (npc),
    .redirect      (redirect)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= RUN;
      pend_target_q    <= 32'd0;
      pc_front_q       <= RESET_PC;
      flush_q          <= 1'b0;
      align_fault_q    <= 1'b0;
      redirect_count_q <= '0;
    end else begin
      state_q          <= state_d;
      pend_target_q    <= pend_target_d;
      pc_front_q       <= pc_front_d;
      flush_q          <= flush_d;
      align_fault_q    <= align_fault_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pend_target_d    = pend_target_q;
    pc_front_d       = pc_front_q;
    flush_d          = 1'b0;
    align_fault_d    = branch_taken & (|branch_target[1:0]);
    redirect_count_d = redirect_count_q;
    if (LE) begin
      pc_front_d = npc;
      // A live branch outranks the pending target inside npc_mux, so a
      // collision in PEND is counted and flushed exactly once.
      if (redirect) begin
        state_d = RUN;
        flush_d = 1'b1;
        if (redirect_count_q != '1) begin
          redirect_count_d = redirect_count_q + CNT_W'(1);
        end
      end
    end else if (branch_taken) begin
      pend_target_d = word_align(branch_target);
      state_d       = PEND;
    end
  end

  always_comb begin
    npc_out          = npc;
    pc_front_out     = pc_front_q;
    redirect_pending = (state_q == PEND);
    flush_out        = flush_q;
    align_fault      = align_fault_q;
    redirect_count   = redirect_count_q;
  end

endmodule

// File: doc/pc_front_seq.md
# pc_front_seq

Next-PC sequencer and PC-front register for the PA-RISC fetch pipeline. It selects the next fetch address from the sequential PC back value, an immediate branch target, or a branch target held pending across a stall, and registers that address as PC front. Its combinational next-PC output drives the PC-back stage, so PC back always tracks PC front + 4. It also emits a one-cycle flush pulse to the fetch/decode latches after every applied redirect.

## Interface
Parameters:
- RESET_PC, 32'd0: PC front value after reset. PC back resets to RESET_PC + 4.
- CNT_W, 16: width of the redirect counter.

Ports:
- clk  in  1  clock. All state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- LE  in  1  load enable, shared with the PC-back stage. 0 = pipeline stall.
- pc_back_in  in  32  current PC back value (sequential next address).
- branch_taken  in  1  branch/jump resolved taken this cycle.
- branch_target  in  32  target address, valid when branch_taken = 1.
- npc_out  out  32  combinational next PC. Feeds the PC-back stage input.
- pc_front_out  out  32  registered PC front, used as the fetch address.
- redirect_pending  out  1  a stalled redirect is held (state PEND).
- flush_out  out  1  registered one-cycle pulse after a redirect is applied.
- align_fault  out  1  registered one-cycle pulse: an accepted target had bits [1:0] != 0.
- redirect_count  out  CNT_W  saturating count of applied redirects.

## Operation
- FSM states: RUN and PEND. Reset state is RUN.
- Target word-alignment: tgt = {target[31:2], 2'b00}. The same rule applies to pending targets.
- npc_out selection, priority high to low:
  - branch_taken = 1: tgt(branch_target).
  - state PEND: pend_target.
  - otherwise: pc_back_in.
- Update rules:
  - LE = 1: pc_front <= npc_out.
  - LE = 1 and a redirect is selected (branch_taken, or PEND): state <= RUN, flush_out <= 1, redirect_count increments (saturating).
  - LE = 0 and branch_taken = 1: pend_target <= tgt(branch_target), state <= PEND. A newer branch overwrites an older pending one. No flush and no count change.
  - LE = 0 and branch_taken = 0: all state holds.
- A branch taken while in PEND with LE = 1 wins over the pending target. The pending target is discarded and the redirect is counted once.
- align_fault pulses on the cycle after any branch_taken whose target[1:0] != 0, regardless of LE.
- redirect_count holds at all-ones once saturated.

## Timing
- Reset values: pc_front_out = RESET_PC, state = RUN, redirect_pending = 0, flush_out = 0, align_fault = 0, redirect_count = 0, pend_target = 0.
- Reset mid-operation (including while in PEND) clears everything on the next edge, and the pending target is lost.
- Latency:
  - npc_out is zero-latency from its inputs.
  - pc_front_out updates one edge after npc_out is selected.
  - flush_out and align_fault assert one cycle after the triggering edge and last exactly one cycle.
- redirect_pending equals (state == PEND) and is registered.
- Reset and LE both high: reset wins.
- PC wrap: sequential addresses wrap modulo 2^32. No fault is raised.

## Structure
- Shared package (fetch_pkg): state encoding (RUN = 1'b0, PEND = 1'b1), RESET_PC default, word-align mask constant.
- One natural sub-module: npc_mux (3-way priority select plus alignment masking).
- The FSM, the registers and the counter live in the top module.

## Test plan
- Reset: hold reset for 2 cycles -> pc_front_out = 0, redirect_count = 0, flush_out = 0. The pc_back stage on npc_out then shows 4.
- Sequential run: LE = 1, pc_back_in tracks front + 4 over 4 cycles -> pc_front_out goes 0, 4, 8, 12, 16, and flush_out stays 0.
- Immediate branch: LE = 1, branch_taken = 1, target 0x100 -> npc_out = 0x100 in the same cycle, pc_front_out = 0x100 next edge, one flush_out pulse, redirect_count = 1.
- Stalled branch: LE = 0 with branch to 0x200, then a second branch to 0x300, then LE = 1 -> redirect_pending = 1 and pc_front_out unchanged during the stall; on release npc_out = 0x300, pc_front_out = 0x300, one flush, count increments by 1.
- Collision and alignment: in PEND (0x200) with LE = 1, branch_taken to 0x403 -> pc_front_out = 0x400, align_fault pulses, pending target discarded, redirect_pending = 0.
- Reset in PEND: pend 0x500, assert reset -> pc_front_out = 0 and redirect_pending = 0. After release, sequential fetch resumes at 4 with no flush.
